// File: rtl/mem_pkg.sv
// Shared packet-buffer SRAM geometry and arbiter defaults.
package mem_pkg;
  localparam int NUM_BLOCKS        = 64;
  localparam int ADDR_W            = $clog2(NUM_BLOCKS);
  localparam int BLOCK_BITS        = 32;
  localparam int NUM_PORTS_DEFAULT = 4;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and SRAM-side bus of mem_arbiter; slave is the arbiter view.
interface mem_arbiter_if import mem_pkg::*; #(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT
) ();
    logic [NUM_PORTS-1:0]                 wr_req_i;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]     wr_addr_i;
    logic [NUM_PORTS-1:0][BLOCK_BITS-1:0] wr_data_i;
    logic [NUM_PORTS-1:0]                 wr_gnt_o;
    logic [NUM_PORTS-1:0]                 rd_req_i;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]     rd_addr_i;
    logic [NUM_PORTS-1:0]                 rd_gnt_o;
    logic [NUM_PORTS-1:0]                 rd_valid_o;
    logic [BLOCK_BITS-1:0]                rd_data_o;
    logic                                 sram_we_o;
    logic [ADDR_W-1:0]                    sram_waddr_o;
    logic [BLOCK_BITS-1:0]                sram_wdata_o;
    logic [ADDR_W-1:0]                    sram_raddr_o;
    logic [BLOCK_BITS-1:0]                sram_rdata_i;

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, sram_rdata_i,
        output wr_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o,
               sram_we_o, sram_waddr_o, sram_wdata_o, sram_raddr_o
    );

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, sram_rdata_i,
        input  wr_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o,
               sram_we_o, sram_waddr_o, sram_wdata_o, sram_raddr_o
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Stateless round-robin picker: first requester at or above ptr, wrapping.
module rr_picker import mem_pkg::*; #(
    parameter  int NUM_PORTS = NUM_PORTS_DEFAULT,
    localparam int PTR_W     = ptr_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PTR_W-1:0]     next_ptr
);
    logic [NUM_PORTS-1:0] w_mask;
    logic [NUM_PORTS-1:0] w_hi;
    logic [NUM_PORTS-1:0] w_src;

    // Prefer requesters at/above ptr; fall back to the lowest one to wrap.
    always_comb begin
        w_mask   = ~((NUM_PORTS'(1) << ptr) - NUM_PORTS'(1));
        w_hi     = req & w_mask;
        w_src    = (|w_hi) ? w_hi : req;
        gnt      = w_src & (~w_src + NUM_PORTS'(1));
        next_ptr = ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) next_ptr = (i == NUM_PORTS - 1) ? '0 : PTR_W'(i + 1);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Independent round-robin write/read arbitration in front of the packet SRAM.
// Define MEM_ARB_FWD_EN for same-cycle write-to-read forwarding.
module mem_arbiter import mem_pkg::*; #(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int PTR_W = ptr_w(NUM_PORTS);

    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [PTR_W-1:0]      w_wr_nxt, w_rd_nxt;
    logic [NUM_PORTS-1:0]  w_wr_req, w_rd_req;
    logic [NUM_PORTS-1:0]  w_wr_gnt, w_rd_gnt;
    logic [NUM_PORTS-1:0]  r_rd_gnt_q;
    logic                  w_we;
    logic [ADDR_W-1:0]     w_waddr, w_raddr;
    logic [BLOCK_BITS-1:0] w_wdata;

    // No grant may escape while reset is held.
    assign w_wr_req = rst_n ? bus.wr_req_i : '0;
    assign w_rd_req = rst_n ? bus.rd_req_i : '0;

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_wr_pick (
        .req(w_wr_req), .ptr(r_wr_ptr), .gnt(w_wr_gnt), .next_ptr(w_wr_nxt)
    );

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_rd_pick (
        .req(w_rd_req), .ptr(r_rd_ptr), .gnt(w_rd_gnt), .next_ptr(w_rd_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_gnt_q <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_rd_gnt_q <= w_rd_gnt;
        end
    end

    // One-hot grants make an OR-reduce mux; idle buses stay at zero.
    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        w_raddr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_wr_gnt[i]) begin
                w_waddr = w_waddr | bus.wr_addr_i[i];
                w_wdata = w_wdata | bus.wr_data_i[i];
            end
            if (w_rd_gnt[i]) w_raddr = w_raddr | bus.rd_addr_i[i];
        end
    end

    assign w_we             = |w_wr_gnt;
    assign bus.wr_gnt_o     = w_wr_gnt;
    assign bus.rd_gnt_o     = w_rd_gnt;
    assign bus.rd_valid_o   = r_rd_gnt_q;
    assign bus.sram_we_o    = w_we;
    assign bus.sram_waddr_o = w_waddr;
    assign bus.sram_wdata_o = w_wdata;
    assign bus.sram_raddr_o = w_raddr;

`ifdef MEM_ARB_FWD_EN
    logic                  r_fwd_q;
    logic [BLOCK_BITS-1:0] r_fwd_data_q;

    // SRAM returns pre-write data on a collision; substitute the written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_q      <= 1'b0;
            r_fwd_data_q <= '0;
        end else begin
            r_fwd_q      <= w_we && (w_waddr == w_raddr);
            r_fwd_data_q <= w_wdata;
        end
    end

    assign bus.rd_data_o = r_fwd_q ? r_fwd_data_q : bus.sram_rdata_i;
`else
    assign bus.rd_data_o = bus.sram_rdata_i;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter with a behavioural SRAM and reference model.
module tb_mem_arbiter;
    import mem_pkg::*;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_PORTS(NP)) bus ();
    mem_arbiter #(.NUM_PORTS(NP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Behavioural SRAM: write at clock edge, registered read of old contents.
    logic [BLOCK_BITS-1:0] sram [NUM_BLOCKS] = '{default: '0};
    always @(posedge clk) begin
        if (bus.sram_we_o) sram[bus.sram_waddr_o] <= bus.sram_wdata_o;
        bus.sram_rdata_i <= sram[bus.sram_raddr_o];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                    m_wp = 0, m_rp = 0;
    logic [BLOCK_BITS-1:0] m_mem [NUM_BLOCKS] = '{default: '0};
    logic [NP-1:0]         m_vld = '0;
    logic [BLOCK_BITS-1:0] m_data = '0;
    logic [NP-1:0]         m_last_wg = '0, m_last_rg = '0;

    // Observed outputs of the last cycle, for directed checks
    logic [NP-1:0]         obs_wg, obs_rg, obs_vld;
    logic [BLOCK_BITS-1:0] obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] req, input int ptr);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (ptr + k) % NP;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    task automatic cycle();
        int wg, rg;
        logic [NP-1:0] ewg, erg;
        logic [ADDR_W-1:0] ewa, era;
        logic [BLOCK_BITS-1:0] ewd;
        @(negedge clk);
        if (!rst_n) m_vld = '0;
        wg  = rst_n ? pick(bus.wr_req_i, m_wp) : -1;
        rg  = rst_n ? pick(bus.rd_req_i, m_rp) : -1;
        ewg = (wg >= 0) ? NP'(1) << wg : '0;
        erg = (rg >= 0) ? NP'(1) << rg : '0;
        ewa = (wg >= 0) ? bus.wr_addr_i[wg] : '0;
        ewd = (wg >= 0) ? bus.wr_data_i[wg] : '0;
        era = (rg >= 0) ? bus.rd_addr_i[rg] : '0;
        obs_wg = bus.wr_gnt_o; obs_rg = bus.rd_gnt_o;
        obs_vld = bus.rd_valid_o; obs_data = bus.rd_data_o;
        chk("wr_gnt", 32'(bus.wr_gnt_o), 32'(ewg));
        chk("rd_gnt", 32'(bus.rd_gnt_o), 32'(erg));
        chk("sram_we", 32'(bus.sram_we_o), 32'(wg >= 0));
        chk("sram_waddr", 32'(bus.sram_waddr_o), 32'(ewa));
        chk("sram_wdata", bus.sram_wdata_o, ewd);
        chk("sram_raddr", 32'(bus.sram_raddr_o), 32'(era));
        chk("rd_valid", 32'(bus.rd_valid_o), 32'(m_vld));
        if (m_vld != '0) chk("rd_data", bus.rd_data_o, m_data);
        if (rst_n) begin
            if (wg >= 0) m_wp = (wg + 1) % NP;
            if (rg >= 0) m_rp = (rg + 1) % NP;
            m_vld = erg;
`ifdef MEM_ARB_FWD_EN
            m_data = (wg >= 0 && ewa == era) ? ewd : m_mem[era];
`else
            m_data = m_mem[era];
`endif
            if (wg >= 0) m_mem[ewa] = ewd;
        end else begin
            m_wp = 0; m_rp = 0; m_vld = '0;
        end
        m_last_wg = ewg; m_last_rg = erg;
        @(posedge clk);
        #1;
        if (!rst_n) begin m_wp = 0; m_rp = 0; end
    endtask

    task automatic idle();
        bus.wr_req_i = '0;
        bus.rd_req_i = '0;
    endtask

    initial begin
        bus.wr_req_i = '1; bus.rd_req_i = '1;
        bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.rd_addr_i = '0;

        // Reset with every request high: no grants, no valid
        cycle();
        chk("rst_wgnt", 32'(obs_wg), 0);
        chk("rst_rgnt", 32'(obs_rg), 0);
        chk("rst_vld", 32'(obs_vld), 0);

        // Fairness: all four requesting for 8 cycles
        rst_n = 1'b1;
        for (int p = 0; p < NP; p++) begin
            bus.wr_addr_i[p] = ADDR_W'(p + 8);
            bus.wr_data_i[p] = 32'hC0DE_0000 + 32'(p);
            bus.rd_addr_i[p] = ADDR_W'(p);
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk($sformatf("rr_wr%0d", k), 32'(obs_wg), 32'(1) << (k % NP));
            chk($sformatf("rr_rd%0d", k), 32'(obs_rg), 32'(1) << (k % NP));
        end

        // Skip/wrap: grant port 2, then only 1 and 3 request
        bus.wr_req_i = 4'b0100; bus.rd_req_i = 4'b0100;
        cycle();
        chk("skip_g2", 32'(obs_wg), 32'h4);
        bus.wr_req_i = 4'b1010; bus.rd_req_i = 4'b1010;
        cycle();
        chk("skip_wr3", 32'(obs_wg), 32'h8);
        chk("skip_rd3", 32'(obs_rg), 32'h8);
        bus.wr_req_i = 4'b0010; bus.rd_req_i = 4'b0010;
        cycle();
        chk("wrap_wr1", 32'(obs_wg), 32'h2);
        chk("wrap_rd1", 32'(obs_rg), 32'h2);

        // Write-then-read: port 1 writes 0xA5 to 7, port 2 reads it next cycle
        idle();
        bus.wr_req_i = 4'b0010; bus.wr_addr_i[1] = 7; bus.wr_data_i[1] = 32'hA5;
        cycle();
        idle();
        bus.rd_req_i = 4'b0100; bus.rd_addr_i[2] = 7;
        cycle();
        idle();
        cycle();
        chk("wtr_vld", 32'(obs_vld), 32'h4);
        chk("wtr_data", obs_data, 32'hA5);

        // Collision on address 3
        bus.wr_req_i = 4'b0001; bus.wr_addr_i[0] = 3; bus.wr_data_i[0] = 32'h11;
        cycle();
        idle();
        bus.wr_req_i = 4'b0010; bus.wr_addr_i[1] = 3; bus.wr_data_i[1] = 32'h22;
        bus.rd_req_i = 4'b0010; bus.rd_addr_i[1] = 3;
        cycle();
        idle();
        cycle();
        chk("coll_vld", 32'(obs_vld), 32'h2);
`ifdef MEM_ARB_FWD_EN
        chk("coll_data", obs_data, 32'h22);
`else
        chk("coll_data", obs_data, 32'h11);
`endif

        // Reset mid-read: the granted read never becomes valid
        bus.rd_req_i = 4'b0001; bus.rd_addr_i[0] = 5;
        cycle();
        chk("mid_gnt", 32'(obs_rg), 32'h1);
        idle();
        rst_n = 1'b0;
        cycle();
        chk("mid_vld", 32'(obs_vld), 0);
        rst_n = 1'b1;
        bus.wr_req_i = 4'b1000; bus.rd_req_i = 4'b1000;
        cycle();
        chk("post_vld", 32'(obs_vld), 0);
        chk("post_wgnt", 32'(obs_wg), 32'h8);

        // Random traffic, requests held until granted
        idle();
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!bus.wr_req_i[p] || m_last_wg[p]) begin
                    bus.wr_req_i[p]  = ($urandom_range(0, 9) < 6);
                    bus.wr_addr_i[p] = ADDR_W'($urandom_range(0, 7));
                    bus.wr_data_i[p] = $urandom;
                end
                if (!bus.rd_req_i[p] || m_last_rg[p]) begin
                    bus.rd_req_i[p]  = ($urandom_range(0, 9) < 6);
                    bus.rd_addr_i[p] = ADDR_W'($urandom_range(0, 7));
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-write/single-read packet-buffer SRAM among `NUM_PORTS` ingress writers and `NUM_PORTS` egress readers. It sits directly in front of the `sram` instance:
- drives its `we_i`/`w_addr_i`/`w_data_i` and `r_addr_i`;
- returns `r_data_o` to the requesting reader with a registered per-port valid.

Write and read sides arbitrate independently, so one write and one read complete every cycle.

## Interface
- `NUM_PORTS`, default 4: number of requesters per side; must be ≥2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `wr_req_i`  in  NUM_PORTS: per-port write request; held until granted.
- `wr_addr_i`  in  NUM_PORTS×ADDR_W: per-port block address.
- `wr_data_i`  in  NUM_PORTS×BLOCK_BITS: per-port write data.
- `wr_gnt_o`  out  NUM_PORTS: one-hot write grant; combinational. Transfer occurs when `req & gnt`.
- `rd_req_i`  in  NUM_PORTS: per-port read request; held until granted.
- `rd_addr_i`  in  NUM_PORTS×ADDR_W: per-port read address.
- `rd_gnt_o`  out  NUM_PORTS: one-hot read grant; combinational.
- `rd_valid_o`  out  NUM_PORTS: one-hot, registered. Marks `rd_data_o` valid for the port granted in the previous cycle.
- `rd_data_o`  out  BLOCK_BITS: shared read data bus.
- `sram_we_o`  out  1: connects to SRAM `we_i`.
- `sram_waddr_o`  out  ADDR_W: connects to SRAM `w_addr_i`.
- `sram_wdata_o`  out  BLOCK_BITS: connects to SRAM `w_data_i`.
- `sram_raddr_o`  out  ADDR_W: connects to SRAM `r_addr_i`.
- `sram_rdata_i`  in  BLOCK_BITS: connects from SRAM `r_data_o`.

## Operation
- **Write pointer `wr_ptr`** (log2 NUM_PORTS bits): the grant goes to the first requesting port at or after `wr_ptr`, searching upward with wrap-around.
  - On any grant, `wr_ptr` becomes granted+1, wrapping from NUM_PORTS-1 to 0.
  - With no request, `wr_ptr` holds.
- **Read pointer `rd_ptr`**: identical, independent of `wr_ptr`.
- **Write path:** `sram_we_o = |wr_gnt_o`. Address and data are muxed from the granted port; when `sram_we_o`=0 they are zero.
- **Read path:** `sram_raddr_o` is muxed from the granted read port; zero when nothing is granted.
  - Register `rd_gnt_q <= rd_gnt_o`; `rd_valid_o = rd_gnt_q`.
  - `rd_data_o = sram_rdata_i` (forwarded value when enabled), independent of valid.
- **Requester rules:** a requester must keep req/addr/data stable until granted. Deasserting req before grant is legal and simply withdraws the request.
- **Same-address collision** (write and read to the same address in the same cycle): the SRAM returns the old data unless forwarding is enabled; see Configuration.
- **Reset:** asserting `rst_n` low clears `wr_ptr`, `rd_ptr` and `rd_gnt_q` to 0, so `rd_valid_o` is 0.
  - A read granted in the cycle before reset never produces a valid.
  - Grants remain combinational from req, but are forced to 0 while `rst_n` is low.

## Timing
- Write: granted in cycle N; SRAM updated at the end of cycle N; readable by a read granted in cycle N+1 or later.
- Read latency: grant in cycle N → `rd_valid_o` and data in cycle N+1. Throughput is one read per cycle, back-to-back across ports.
- Worst-case wait with all ports requesting continuously: NUM_PORTS-1 grants.
- No combinational path from `sram_rdata_i` to any grant.

## Configuration
- `MEM_ARB_FWD_EN` defined: same-cycle write/read forwarding.
  - If `sram_we_o` and `sram_waddr_o == sram_raddr_o` in cycle N, register `fwd_q`=1 and `fwd_data_q = sram_wdata_o`.
  - In cycle N+1, `rd_data_o = fwd_data_q`.
  - `fwd_q` resets to 0.
- Undefined: no forwarding registers; `rd_data_o = sram_rdata_i` always, so a collision returns the pre-write contents.

## Structure
- `ADDR_W`, `BLOCK_BITS`, `NUM_BLOCKS` come from `mem_pkg`. Add `NUM_PORTS_DEFAULT` there.
- One sub-module, `rr_picker`: parameterised NUM_PORTS; inputs `req` and `ptr`; outputs one-hot `gnt` and `next_ptr`.
  - Instantiated twice, once for writes and once for reads.
  - Holds no state; the pointers are registered in `mem_arbiter`.

## Test plan
- **Reset:** `rst_n` low with all reqs high → all grants 0 and `rd_valid_o`=0. After release, first write grant = port 0, first read grant = port 0.
- **Round-robin fairness:** NUM_PORTS=4, all four `wr_req_i` held for 8 cycles → grant sequence 0,1,2,3,0,1,2,3; same check on the read side.
- **Pointer skip/wrap:** after a grant to port 2, only ports 1 and 3 requesting → port 3 granted, then port 1.
- **Write-then-read:**
  - Port 1 writes 0xA5 to address 7 in cycle N.
  - Port 2 reads address 7 in cycle N+1.
  - In N+2: `rd_valid_o`=0b0100 and `rd_data_o`=0xA5.
- **Collision:** address 3 holds 0x11; same cycle, write 0x22 to 3 and read 3 → next cycle data = 0x22 with `MEM_ARB_FWD_EN`, 0x11 without.
- **Reset mid-read:** read granted in cycle N, `rst_n` low in N+1 → `rd_valid_o` stays 0.
